// File: rtl/pkg_elevador.sv
// rtl/pkg_elevador.sv - shared elevator defaults and call record type
package pkg_elevador;

  localparam int ANDAR_W_PADRAO      = 4;
  localparam int PROFUNDIDADE_PADRAO = 8;

  // One complete call: where the passenger is and where they want to go.
  typedef struct packed {
    logic [ANDAR_W_PADRAO-1:0] origem;
    logic [ANDAR_W_PADRAO-1:0] destino;
  } chamada_t;

endpackage

// File: rtl/ram_chamadas.sv
// rtl/ram_chamadas.sv - call storage, one synchronous write port, one asynchronous read port
module ram_chamadas #(
  parameter int PROFUNDIDADE = 8,
  parameter int LARGURA      = 8
) (
  input  logic                            clock,
  input  logic                            escreve,
  input  logic [$clog2(PROFUNDIDADE)-1:0] endereco_escrita,
  input  logic [LARGURA-1:0]              dado_escrita,
  input  logic [$clog2(PROFUNDIDADE)-1:0] endereco_leitura,
  output logic [LARGURA-1:0]              dado_leitura
);

  logic [LARGURA-1:0] memoria [PROFUNDIDADE];

  // Store a call; contents are deliberately left uninitialised on reset.
  always_ff @(posedge clock) begin
    if (escreve) begin
      memoria[endereco_escrita] <= dado_escrita;
    end
  end

  assign dado_leitura = memoria[endereco_leitura];

endmodule

// File: rtl/fila_chamadas.sv
// rtl/fila_chamadas.sv - origin/destination pairing and show-ahead FIFO of elevator calls
module fila_chamadas
  import pkg_elevador::*;
#(
  parameter int ANDAR_W      = ANDAR_W_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [ANDAR_W-1:0]              andar_entrada,
  input  logic                            escreve,
  input  logic                            seleciona_origem,
  input  logic                            consome,
  output logic [ANDAR_W-1:0]              saida_origem,
  output logic [ANDAR_W-1:0]              saida_destino,
  output logic                            saida_valida,
  output logic                            vazia,
  output logic                            cheia,
  output logic [$clog2(PROFUNDIDADE):0]   contagem,
  output logic                            pendente,
  output logic                            erro_sequencia,
  output logic                            transbordo
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CHEIO = CW'(PROFUNDIDADE);

  logic [PW-1:0]          ptr_leitura;
  logic [PW-1:0]          ptr_escrita;
  logic [ANDAR_W-1:0]     origem_reg;
  logic [2*ANDAR_W-1:0]   dado_cabeca;
  logic                   escreve_destino;
  logic                   pedido_push;
  logic                   push;
  logic                   pop;

  assign vazia        = (contagem == '0);
  assign cheia        = (contagem == CHEIO);
  assign saida_valida = !vazia;

  assign escreve_destino = escreve && !seleciona_origem;
  // A pair whose two floors match is not a trip, so it never reaches the queue.
  assign pedido_push     = escreve_destino && pendente && (andar_entrada != origem_reg);
  assign pop             = consome && !vazia;
  // A pop in the same cycle frees the slot a full queue would otherwise lack.
  assign push            = pedido_push && (!cheia || pop);

  ram_chamadas #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARGURA      (2 * ANDAR_W)
  ) u_ram (
    .clock            (clock),
    .escreve          (push),
    .endereco_escrita (ptr_escrita),
    .dado_escrita     ({origem_reg, andar_entrada}),
    .endereco_leitura (ptr_leitura),
    .dado_leitura     (dado_cabeca)
  );

  assign saida_origem  = vazia ? '0 : dado_cabeca[2*ANDAR_W-1:ANDAR_W];
  assign saida_destino = vazia ? '0 : dado_cabeca[ANDAR_W-1:0];

  // Origin latch and pending flag; a new origin simply replaces a pending one.
  always_ff @(posedge clock) begin
    if (reset) begin
      origem_reg <= '0;
      pendente   <= 1'b0;
    end else if (escreve && seleciona_origem) begin
      origem_reg <= andar_entrada;
      pendente   <= 1'b1;
    end else if (escreve_destino) begin
      pendente   <= 1'b0;
    end
  end

  // Error pulse for an orphan destination and sticky overflow on a dropped call.
  always_ff @(posedge clock) begin
    if (reset) begin
      erro_sequencia <= 1'b0;
      transbordo     <= 1'b0;
    end else begin
      erro_sequencia <= escreve_destino && !pendente;
      if (pedido_push && !push) begin
        transbordo <= 1'b1;
      end
    end
  end

  // Read/write pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_escrita <= '0;
      ptr_leitura <= '0;
    end else begin
      if (push) ptr_escrita <= ptr_escrita + PW'(1);
      if (pop)  ptr_leitura <= ptr_leitura + PW'(1);
    end
  end

  // Occupancy counter; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      contagem <= '0;
    end else begin
      case ({push, pop})
        2'b10:   contagem <= contagem + CW'(1);
        2'b01:   contagem <= contagem - CW'(1);
        default: contagem <= contagem;
      endcase
    end
  end

endmodule

// File: tb/tb_fila_chamadas.sv
// tb/tb_fila_chamadas.sv - self-checking bench for fila_chamadas
module tb_fila_chamadas;
  import pkg_elevador::*;

  localparam int AW = 4;
  localparam int P  = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] andar_entrada;
  logic          escreve;
  logic          seleciona_origem;
  logic          consome;
  logic [AW-1:0] saida_origem;
  logic [AW-1:0] saida_destino;
  logic          saida_valida;
  logic          vazia;
  logic          cheia;
  logic [CW-1:0] contagem;
  logic          pendente;
  logic          erro_sequencia;
  logic          transbordo;

  always #5 clock = ~clock;

  fila_chamadas #(.ANDAR_W(AW), .PROFUNDIDADE(P)) dut (
    .clock            (clock),
    .reset            (reset),
    .andar_entrada    (andar_entrada),
    .escreve          (escreve),
    .seleciona_origem (seleciona_origem),
    .consome          (consome),
    .saida_origem     (saida_origem),
    .saida_destino    (saida_destino),
    .saida_valida     (saida_valida),
    .vazia            (vazia),
    .cheia            (cheia),
    .contagem         (contagem),
    .pendente         (pendente),
    .erro_sequencia   (erro_sequencia),
    .transbordo       (transbordo)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nome, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nome, act, exp);
  endtask

  // Reference model: a plain queue of calls plus the pending origin.
  chamada_t      mq[$];
  logic          m_pend;
  logic [AW-1:0] m_org;
  logic          m_erro;
  logic          m_tr;

  task automatic modelo(input logic r, input logic e, input logic s,
                        input logic [AW-1:0] a, input logic c);
    bit tem_pop;
    chamada_t nova;
    if (r) begin
      mq.delete();
      m_pend = 1'b0;
      m_org  = '0;
      m_erro = 1'b0;
      m_tr   = 1'b0;
    end else begin
      tem_pop = c && (mq.size() > 0);
      m_erro  = e && !s && !m_pend;
      if (tem_pop) void'(mq.pop_front());
      if (e && s) begin
        m_org  = a;
        m_pend = 1'b1;
      end else if (e && !s && m_pend) begin
        m_pend = 1'b0;
        if (a != m_org) begin
          nova.origem  = m_org;
          nova.destino = a;
          if (mq.size() < P) mq.push_back(nova);
          else m_tr = 1'b1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and sample just after the edge.
  task automatic ciclo(input logic r, input logic e, input logic s,
                       input logic [AW-1:0] a, input logic c);
    reset = r; escreve = e; seleciona_origem = s; andar_entrada = a; consome = c;
    modelo(r, e, s, a, c);
    @(posedge clock);
    #1;
    reset = 1'b0; escreve = 1'b0; seleciona_origem = 1'b0; andar_entrada = '0; consome = 1'b0;
  endtask

  task automatic chamada(input logic [AW-1:0] o, input logic [AW-1:0] d, input logic c);
    ciclo(1'b0, 1'b1, 1'b1, o, 1'b0);
    ciclo(1'b0, 1'b1, 1'b0, d, c);
  endtask

  task automatic confere_modelo(input string tag);
    int eo, ed;
    eo = (mq.size() > 0) ? int'(mq[0].origem)  : 0;
    ed = (mq.size() > 0) ? int'(mq[0].destino) : 0;
    chk({tag, ".valida"},     saida_valida,   mq.size() > 0);
    chk({tag, ".vazia"},      vazia,          mq.size() == 0);
    chk({tag, ".cheia"},      cheia,          mq.size() == P);
    chk({tag, ".contagem"},   contagem,       mq.size());
    chk({tag, ".origem"},     saida_origem,   eo);
    chk({tag, ".destino"},    saida_destino,  ed);
    chk({tag, ".pendente"},   pendente,       m_pend);
    chk({tag, ".erro"},       erro_sequencia, m_erro);
    chk({tag, ".transbordo"}, transbordo,     m_tr);
  endtask

  typedef struct {
    logic          r, e, s;
    logic [AW-1:0] a;
    logic          c;
    logic          v;
    logic [AW-1:0] o, d;
    int            n;
    logic          p, er, t;
  } vec_t;

  vec_t tab[12];

  initial begin
    reset = 1'b0; escreve = 1'b0; seleciona_origem = 1'b0; andar_entrada = '0; consome = 1'b0;
    mq.delete(); m_pend = 1'b0; m_org = '0; m_erro = 1'b0; m_tr = 1'b0;

    //            r  e  s  a  c   v  o  d  n  p  er t
    tab[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tab[1]  = '{0, 1, 1, 3, 0,  0, 0, 0, 0, 1, 0, 0};
    tab[2]  = '{0, 1, 0, 7, 0,  1, 3, 7, 1, 0, 0, 0};
    tab[3]  = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0};
    tab[4]  = '{0, 1, 0, 5, 0,  0, 0, 0, 0, 0, 1, 0};
    tab[5]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tab[6]  = '{0, 1, 1, 2, 0,  0, 0, 0, 0, 1, 0, 0};
    tab[7]  = '{0, 1, 1, 4, 0,  0, 0, 0, 0, 1, 0, 0};
    tab[8]  = '{0, 1, 0, 6, 0,  1, 4, 6, 1, 0, 0, 0};
    tab[9]  = '{0, 1, 1, 5, 0,  1, 4, 6, 1, 1, 0, 0};
    tab[10] = '{0, 1, 0, 5, 0,  1, 4, 6, 1, 0, 0, 0};
    tab[11] = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0};

    @(negedge clock);
    for (int i = 0; i < 12; i++) begin
      ciclo(tab[i].r, tab[i].e, tab[i].s, tab[i].a, tab[i].c);
      chk($sformatf("tab%0d.valida", i),   saida_valida,   tab[i].v);
      chk($sformatf("tab%0d.vazia", i),    vazia,          !tab[i].v);
      chk($sformatf("tab%0d.origem", i),   saida_origem,   tab[i].o);
      chk($sformatf("tab%0d.destino", i),  saida_destino,  tab[i].d);
      chk($sformatf("tab%0d.contagem", i), contagem,       tab[i].n);
      chk($sformatf("tab%0d.pendente", i), pendente,       tab[i].p);
      chk($sformatf("tab%0d.erro", i),     erro_sequencia, tab[i].er);
      chk($sformatf("tab%0d.transb", i),   transbordo,     tab[i].t);
    end

    // Fill to capacity, then overflow, then overflow rescued by a same-cycle pop.
    ciclo(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < P; i++) chamada(AW'(i), AW'(i + 1), 1'b0);
    chk("cheio.cheia", cheia, 1);
    chk("cheio.contagem", contagem, 8);
    chk("cheio.transbordo", transbordo, 0);
    chamada(4'd9, 4'd10, 1'b0);
    chk("nono.transbordo", transbordo, 1);
    chk("nono.contagem", contagem, 8);
    chk("nono.origem", saida_origem, 0);
    chk("nono.destino", saida_destino, 1);
    chamada(4'd9, 4'd10, 1'b1);
    chk("nono_pop.contagem", contagem, 8);
    chk("nono_pop.cheia", cheia, 1);
    chk("nono_pop.origem", saida_origem, 1);
    for (int i = 1; i <= P; i++) begin
      chk($sformatf("drena%0d.origem", i), saida_origem, (i == P) ? 9 : i);
      chk($sformatf("drena%0d.destino", i), saida_destino, (i == P) ? 10 : i + 1);
      ciclo(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    chk("drenado.vazia", vazia, 1);

    // Interleaved push/pop across several pointer wraps.
    for (int k = 0; k < 20; k++) begin
      chamada(AW'(k % 16), AW'((k + 3) % 16), 1'b0);
      chk($sformatf("wrap%0d.origem", k), saida_origem, k % 16);
      chk($sformatf("wrap%0d.destino", k), saida_destino, (k + 3) % 16);
      ciclo(1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk($sformatf("wrap%0d.vazia", k), vazia, 1);
    end

    // Reset in the middle of traffic with an origin pending.
    chamada(4'd1, 4'd2, 1'b0);
    chamada(4'd3, 4'd4, 1'b0);
    chamada(4'd5, 4'd6, 1'b0);
    ciclo(1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
    chk("pre_reset.contagem", contagem, 3);
    chk("pre_reset.pendente", pendente, 1);
    ciclo(1'b1, 1'b1, 1'b0, 4'd8, 1'b1);
    chk("reset.contagem", contagem, 0);
    chk("reset.pendente", pendente, 0);
    chk("reset.transbordo", transbordo, 0);
    chk("reset.vazia", vazia, 1);
    ciclo(1'b0, 1'b1, 1'b0, 4'd8, 1'b0);
    chk("pos_reset.erro", erro_sequencia, 1);
    chk("pos_reset.contagem", contagem, 0);

    // Random traffic against the queue model.
    for (int i = 0; i < 800; i++) begin
      ciclo($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0);
      confere_modelo($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fila_chamadas.md
# fila_chamadas

Request queue for the elevator manager, directly downstream of the new-call control unit. It takes floor numbers written one at a time, pairs each origin with the destination that follows it, and stores complete calls in a first-in-first-out buffer. Complete calls are presented to the elevator dispatcher through a valid/consume handshake. It owns the call RAM, including its top-of-queue pointer.

## Interface
- `ANDAR_W`, 4: width of a floor number.
- `PROFUNDIDADE`, 8: number of stored calls; must be a power of two and at least 2.

- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; takes effect on the rising edge of `clock`.
- `andar_entrada`  in  ANDAR_W  floor number being written.
- `escreve`  in  1  write strobe, one cycle per floor (driven by the control unit's RAM enable).
- `seleciona_origem`  in  1  1: `andar_entrada` is an origin; 0: it is a destination.
- `consome`  in  1  dispatcher accepts the head call this cycle.
- `saida_origem`  out  ANDAR_W  origin floor of the head call; 0 when empty.
- `saida_destino`  out  ANDAR_W  destination floor of the head call; 0 when empty.
- `saida_valida`  out  1  head call present (equals !`vazia`).
- `vazia`  out  1  queue holds no complete calls.
- `cheia`  out  1  queue holds PROFUNDIDADE calls.
- `contagem`  out  $clog2(PROFUNDIDADE)+1  number of stored calls.
- `pendente`  out  1  an origin is latched and waiting for its destination.
- `erro_sequencia`  out  1  one-cycle pulse: destination written with no origin pending.
- `transbordo`  out  1  sticky flag: a call was dropped because the queue was full; cleared only by `reset`.

## Operation
- **Origin write** (`escreve` high, `seleciona_origem`=1): the floor is latched into the origin register and `pendente` is set. If an origin is already pending, the new value overwrites it and no error is raised.
- **Destination write** (`escreve` high, `seleciona_origem`=0):
  - With `pendente` set: `pendente` is cleared and the pair {origin, destination} is pushed.
  - Without `pendente`: the write is ignored and `erro_sequencia` pulses for one cycle.
- **Degenerate pair** (origin equals destination): `pendente` is cleared, nothing is pushed and no flag is raised.
- **Push when full:** the call is dropped and `transbordo` is set. Exception: a pop in the same cycle frees a slot, and then the push is accepted.
- **Pop:** occurs when `consome` and `saida_valida` are both high. The read pointer advances and `contagem` decrements. `consome` with an empty queue is ignored.
- **Simultaneous push and pop:** `contagem` is unchanged and both pointers advance.
- **Empty queue:** a push and `consome` in the same cycle causes no pop; the new call becomes the head next cycle.
- **Pointers:** read and write pointers are $clog2(PROFUNDIDADE) bits wide and wrap modulo PROFUNDIDADE.
- **Status outputs:** `cheia`=(`contagem`==PROFUNDIDADE) and `vazia`=(`contagem`==0).
- **Head read:** the queue is show-ahead. The head is read combinationally at the read pointer, with `saida_*` gated to 0 when `vazia`.

## Timing
- **Reset values:** the reset edge clears the pointers, `contagem`, the origin register, `pendente`, `erro_sequencia` and `transbordo`. As a result, `vazia`=1, `cheia`=0, `saida_valida`=0 and `saida_*`=0. Memory contents are not cleared.
- **Reset mid-sequence:** a pending origin is discarded; reset has priority over every same-cycle write or pop.
- **Write-to-valid latency:** a destination strobe sampled at edge N makes `saida_valida` high and the pair visible right after edge N. That is one cycle after the strobe is presented.
- **Pop latency:** a pop at edge N shows the next call, or empty, right after edge N.
- **`erro_sequencia` timing:** asserted for exactly the cycle following the offending edge.
- **Strobe width:** inputs are sampled only when `escreve` is high; a held `escreve` is treated as one write per cycle.

## Structure
- **Shared package `pkg_elevador`:** holds `ANDAR_W` default, `PROFUNDIDADE` default, and a call typedef/struct {origem, destino} of 2·ANDAR_W bits.
- **Sub-module `ram_chamadas`:**
  - register array, PROFUNDIDADE × 2·ANDAR_W;
  - one synchronous write port;
  - one asynchronous read port.
- **`fila_chamadas` proper:** keeps the pairing logic, pointers, counter and flags.

## Test plan
- After reset, write origin 3 then destination 7, then check `saida_valida`=1, `saida_origem`=3, `saida_destino`=7, `contagem`=1. Then pulse `consome`, and check `vazia`=1 and `saida_*`=0.
- Write destination 5 with nothing pending: `erro_sequencia` is high for one cycle, `contagem` stays 0 and `pendente` stays 0.
- Write origin 2, origin 4, destination 6: the stored call is {4,6}; writing origin 5 then destination 5 stores nothing and clears `pendente`.
- Push 8 calls {i, i+1} to reach `cheia`=1, then push a ninth: `transbordo`=1 and `contagem` stays 8. Repeat the ninth push with `consome` high in the same cycle: it is accepted and `contagem` stays 8.
- Push and pop 20 calls interleaved to force pointer wrap: every pair emerges in order, unchanged.
- With 3 calls stored and an origin pending, assert `reset`: on the next cycle `contagem`=0, `pendente`=0, `transbordo`=0 and `vazia`=1; a following destination write raises `erro_sequencia`.
